// File: rtl/use_drain_scheduler_pkg.sv
// Shared types and default sizing for the in-order element drain scheduler.
package use_sched_pkg;

    typedef enum logic {
        S_WAIT = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int DEF_NUM_ELEMENTS = 4;
    localparam int DEF_MAX_BYTES    = 34;
    localparam int DEF_LEN_W        = $clog2(DEF_MAX_BYTES);

    function automatic int idxWidth(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_IDX_W = idxWidth(DEF_NUM_ELEMENTS);

endpackage

// File: rtl/use_drain_scheduler_if.sv
// Outgoing message stream: registered payload with valid/ready handshake.
interface use_drain_scheduler_if #(
    parameter int MAX_BYTES = 34,
    parameter int LEN_W     = 6
);
    logic [MAX_BYTES-1:0][7:0] msgData;
    logic [LEN_W-1:0]          msgLen;
    logic                      msgLast;
    logic                      msgValid;
    logic                      msgReady;

    modport master (
        output msgData, msgLen, msgLast, msgValid,
        input  msgReady
    );

    modport slave (
        input  msgData, msgLen, msgLast, msgValid,
        output msgReady
    );
endinterface

// File: rtl/use_drain_scheduler_stats.sv
// Accepted-message statistics and sticky length-overflow flag.
module use_sched_stats #(
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             accept,
    input  logic [LEN_W-1:0] acceptLen,
    input  logic             acceptLast,
    input  logic             capture,
    input  logic             overLen,
    output logic [15:0]      msgCount,
    output logic [31:0]      byteCount,
    output logic             lenError,
    output logic             frameDone
);

    always_ff @(posedge clk) begin
        if (reset) begin
            msgCount  <= '0;
            byteCount <= '0;
            lenError  <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= accept && acceptLast;
            if (accept) begin
                msgCount  <= msgCount + 16'd1;
                byteCount <= byteCount + 32'(acceptLen);
            end
            if (capture && overLen) begin
                lenError <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/use_drain_scheduler.sv
// Drains per-element messages strictly in ring order into one output slot.
module use_drain_scheduler
    import use_sched_pkg::*;
#(
    parameter int NUM_ELEMENTS           = DEF_NUM_ELEMENTS,
    parameter int MAX_UNCOMPRESSED_BYTES = DEF_MAX_BYTES,
    parameter int LEN_W                  = $clog2(MAX_UNCOMPRESSED_BYTES),
    localparam int IDX_W                 = idxWidth(NUM_ELEMENTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_ELEMENTS-1:0][MAX_UNCOMPRESSED_BYTES-1:0][7:0] elemData,
    input  logic [NUM_ELEMENTS-1:0][LEN_W-1:0] elemLen,
    input  logic [NUM_ELEMENTS-1:0] elemLast,
    output logic [NUM_ELEMENTS-1:0] elemTaken,
    use_drain_scheduler_if.master   msg,
    output logic [IDX_W-1:0]        head,
    output logic [15:0]             msgCount,
    output logic [31:0]             byteCount,
    output logic                    lenError,
    output logic                    frameDone
);

    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_UNCOMPRESSED_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

    state_t           state;
    logic [LEN_W-1:0] headLen;
    logic [LEN_W-1:0] capLen;
    logic             overLen;
    logic             capture;
    logic             drained;
    logic             accept;

    always_comb begin
        headLen = elemLen[head];
        overLen = headLen > MAX_LEN;
        capLen  = overLen ? MAX_LEN : headLen;
        accept  = msg.msgValid && msg.msgReady;
        // The slot frees up in the same cycle it is accepted, so a
        // capture can overlap the handoff for full throughput.
        capture = enable && (headLen != '0) &&
                  ((state == S_WAIT) || msg.msgReady);
        drained = (state == S_HOLD) && msg.msgReady && !capture;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_WAIT;
            head         <= '0;
            elemTaken    <= '0;
            msg.msgValid <= 1'b0;
            msg.msgData  <= '0;
            msg.msgLen   <= '0;
            msg.msgLast  <= 1'b0;
        end else begin
            elemTaken <= '0;
            unique case (1'b1)
                capture: begin
                    msg.msgData     <= elemData[head];
                    msg.msgLen      <= capLen;
                    msg.msgLast     <= elemLast[head];
                    msg.msgValid    <= 1'b1;
                    elemTaken[head] <= 1'b1;
                    head  <= (head == LAST_IDX) ? '0 : head + 1'b1;
                    state <= S_HOLD;
                end
                drained: begin
                    msg.msgValid <= 1'b0;
                    state        <= S_WAIT;
                end
                default: ;
            endcase
        end
    end

    use_sched_stats #(
        .LEN_W (LEN_W)
    ) u_stats (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .acceptLen  (msg.msgLen),
        .acceptLast (msg.msgLast),
        .capture    (capture),
        .overLen    (overLen),
        .msgCount   (msgCount),
        .byteCount  (byteCount),
        .lenError   (lenError),
        .frameDone  (frameDone)
    );

endmodule

// File: tb/tb_use_drain_scheduler.sv
// Bench for use_drain_scheduler: vector table, corner sequences, random vs model.
module tb_use_drain_scheduler;

    localparam int N  = 4;
    localparam int MB = 34;
    localparam int LW = 6;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic [N-1:0][MB-1:0][7:0] elemData;
    logic [N-1:0][LW-1:0] elemLen;
    logic [N-1:0] elemLast;
    logic [N-1:0] elemTaken;
    logic [1:0]   head;
    logic [15:0]  msgCount;
    logic [31:0]  byteCount;
    logic         lenError;
    logic         frameDone;

    use_drain_scheduler_if #(.MAX_BYTES(MB), .LEN_W(LW)) mIf ();

    use_drain_scheduler #(
        .NUM_ELEMENTS           (N),
        .MAX_UNCOMPRESSED_BYTES (MB),
        .LEN_W                  (LW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .elemData  (elemData),
        .elemLen   (elemLen),
        .elemLast  (elemLast),
        .elemTaken (elemTaken),
        .msg       (mIf.master),
        .head      (head),
        .msgCount  (msgCount),
        .byteCount (byteCount),
        .lenError  (lenError),
        .frameDone (frameDone)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkData(input string name,
                           input logic [MB-1:0][7:0] act,
                           input logic [MB-1:0][7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic setLens(input int l0, input int l1,
                           input int l2, input int l3);
        elemLen[0] = LW'(l0);
        elemLen[1] = LW'(l1);
        elemLen[2] = LW'(l2);
        elemLen[3] = LW'(l3);
    endtask

    typedef struct {
        logic         en;
        logic         rdy;
        int           len[N];
        logic         expValid;
        int           expLen;
        logic [N-1:0] expTaken;
        int           expHead;
        int           expCnt;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic en, input logic rdy,
                                input int l0, input int l1,
                                input int l2, input int l3,
                                input logic v, input int ln,
                                input logic [N-1:0] tk,
                                input int hd, input int cn);
        vec_t r;
        r.en = en; r.rdy = rdy;
        r.len[0] = l0; r.len[1] = l1; r.len[2] = l2; r.len[3] = l3;
        r.expValid = v; r.expLen = ln; r.expTaken = tk;
        r.expHead = hd; r.expCnt = cn;
        return r;
    endfunction

    typedef struct {
        logic               valid;
        logic [MB-1:0][7:0] data;
        int                 len;
        logic               last;
        int                 head;
        logic [N-1:0]       taken;
        int                 cnt;
        longint             bytes;
        logic               lenErr;
        logic               fd;
    } mdl_t;

    mdl_t m;

    // One output slot: it empties on acceptance and refills from the ring head.
    function automatic mdl_t step(input mdl_t c);
        mdl_t n;
        logic acc;
        int   l;
        n = c;
        acc = c.valid && mIf.msgReady;
        n.taken = '0;
        n.fd = acc && c.last;
        if (acc) begin
            n.cnt   = (c.cnt + 1) % 65536;
            n.bytes = (c.bytes + c.len) % 64'h1_0000_0000;
        end
        l = int'(elemLen[c.head]);
        if (enable && l != 0 && (!c.valid || mIf.msgReady)) begin
            n.valid  = 1'b1;
            n.data   = elemData[c.head];
            n.len    = (l > MB) ? MB : l;
            n.last   = elemLast[c.head];
            n.lenErr = c.lenErr | (l > MB);
            n.taken[c.head] = 1'b1;
            n.head   = (c.head + 1) % N;
        end else if (acc) begin
            n.valid = 1'b0;
        end
        return n;
    endfunction

    logic [MB-1:0][7:0] saved;
    int idx;

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        mIf.msgReady = 1'b0;
        elemLast = '0;
        elemLen = '0;
        for (int e = 0; e < N; e++)
            for (int b = 0; b < MB; b++)
                elemData[e][b] = 8'(e * 40 + b);

        tbl[0]  = mk(1, 1,  0, 0, 0,  0, 0,  0, 4'b0000, 0, 0);
        tbl[1]  = mk(1, 1, 27, 0, 0,  0, 1, 27, 4'b0001, 1, 0);
        tbl[2]  = mk(1, 1,  0, 0, 0,  0, 0, 27, 4'b0000, 1, 1);
        tbl[3]  = mk(1, 1,  0, 0, 5,  0, 0, 27, 4'b0000, 1, 1);
        tbl[4]  = mk(1, 1,  0, 9, 5,  0, 1,  9, 4'b0010, 2, 1);
        tbl[5]  = mk(1, 1,  0, 0, 5,  0, 1,  5, 4'b0100, 3, 2);
        tbl[6]  = mk(1, 0,  0, 0, 0,  0, 1,  5, 4'b0000, 3, 2);
        tbl[7]  = mk(1, 0,  0, 0, 0, 40, 1,  5, 4'b0000, 3, 2);
        tbl[8]  = mk(1, 1,  0, 0, 0, 40, 1, 34, 4'b1000, 0, 3);
        tbl[9]  = mk(0, 1,  0, 0, 0,  0, 0, 34, 4'b0000, 0, 4);
        tbl[10] = mk(0, 1,  3, 0, 0,  0, 0, 34, 4'b0000, 0, 4);
        tbl[11] = mk(1, 1,  3, 0, 0,  0, 1,  3, 4'b0001, 1, 4);

        doReset();
        chk("rst_valid", 64'(mIf.msgValid), 0);
        chk("rst_len", 64'(mIf.msgLen), 0);
        chk("rst_head", 64'(head), 0);
        chk("rst_taken", 64'(elemTaken), 0);
        chk("rst_stats", {msgCount, byteCount, 14'd0, lenError, frameDone}, 0);

        for (int i = 0; i < 12; i++) begin
            enable = tbl[i].en;
            mIf.msgReady = tbl[i].rdy;
            setLens(tbl[i].len[0], tbl[i].len[1], tbl[i].len[2], tbl[i].len[3]);
            cyc();
            chk($sformatf("v%0d_valid", i), 64'(mIf.msgValid), 64'(tbl[i].expValid));
            chk($sformatf("v%0d_len", i), 64'(mIf.msgLen), 64'(tbl[i].expLen));
            chk($sformatf("v%0d_taken", i), 64'(elemTaken), 64'(tbl[i].expTaken));
            chk($sformatf("v%0d_head", i), 64'(head), 64'(tbl[i].expHead));
            chk($sformatf("v%0d_cnt", i), 64'(msgCount), 64'(tbl[i].expCnt));
            idx = -1;
            for (int e = 0; e < N; e++)
                if (tbl[i].expTaken[e]) idx = e;
            if (idx >= 0)
                chkData($sformatf("v%0d_data", i), mIf.msgData, elemData[idx]);
        end
        chk("clamp_lenError", 64'(lenError), 1);

        // All four ready with continuous accept: one message per cycle.
        setLens(0, 0, 0, 0);
        doReset();
        chk("rst_lenError", 64'(lenError), 0);
        enable = 1'b1;
        mIf.msgReady = 1'b1;
        setLens(10, 20, 30, 4);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("b2b%0d_taken", k), 64'(elemTaken), 64'(4'b0001 << k));
            chk($sformatf("b2b%0d_len", k), 64'(mIf.msgLen), 64'(elemLen[k]));
            chk($sformatf("b2b%0d_valid", k), 64'(mIf.msgValid), 1);
            if (k == 3) setLens(0, 0, 0, 0);
        end
        cyc();
        chk("b2b_end_valid", 64'(mIf.msgValid), 0);
        chk("b2b_head_wrap", 64'(head), 0);
        chk("b2b_cnt", 64'(msgCount), 4);
        chk("b2b_bytes", 64'(byteCount), 64);

        // Backpressure: payload frozen, nothing further taken.
        mIf.msgReady = 1'b0;
        setLens(12, 7, 0, 0);
        for (int b = 0; b < MB; b++) elemData[0][b] = 8'($urandom);
        cyc();
        chk("bp_capture", {mIf.msgValid, 2'b0, mIf.msgLen, elemTaken}, {1'b1, 2'b0, 6'd12, 4'b0001});
        saved = elemData[0];
        for (int b = 0; b < MB; b++) elemData[0][b] = 8'($urandom);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("bp%0d_hold", k), {mIf.msgValid, 2'b0, mIf.msgLen, elemTaken}, {1'b1, 2'b0, 6'd12, 4'b0000});
            chkData($sformatf("bp%0d_data", k), mIf.msgData, saved);
        end
        mIf.msgReady = 1'b1;
        setLens(0, 0, 0, 0);
        cyc();
        chk("bp_release_valid", 64'(mIf.msgValid), 0);
        chk("bp_release_cnt", 64'(msgCount), 5);

        // Last-flagged message: frameDone is a single-cycle pulse.
        setLens(0, 5, 0, 0);
        elemLast = 4'b0010;
        cyc();
        chk("fd_last", 64'(mIf.msgLast), 1);
        chk("fd_before", 64'(frameDone), 0);
        setLens(0, 0, 0, 0);
        elemLast = '0;
        cyc();
        chk("fd_pulse", 64'(frameDone), 1);
        cyc();
        chk("fd_clear", 64'(frameDone), 0);

        // Reset while holding an unaccepted message.
        mIf.msgReady = 1'b0;
        setLens(0, 0, 8, 0);
        cyc();
        chk("rh_hold", 64'(mIf.msgValid), 1);
        reset = 1'b1;
        mIf.msgReady = 1'b1;
        cyc();
        chk("rh_valid", 64'(mIf.msgValid), 0);
        chk("rh_head", 64'(head), 0);
        chk("rh_taken", 64'(elemTaken), 0);
        chk("rh_stats", {msgCount, byteCount, 14'd0, lenError, frameDone}, 0);
        setLens(0, 0, 0, 0);
        reset = 1'b0;
        cyc();

        // Randomised traffic against the slot model.
        m.valid = 0; m.data = '0; m.len = 0; m.last = 0; m.head = 0;
        m.taken = '0; m.cnt = 0; m.bytes = 0; m.lenErr = 0; m.fd = 0;
        for (int c = 0; c < 1500; c++) begin
            enable = ($urandom % 8) != 0;
            mIf.msgReady = ($urandom % 4) != 0;
            for (int e = 0; e < N; e++) begin
                elemLen[e] = ($urandom % 3 == 0) ? '0 : LW'($urandom_range(1, 45));
                elemLast[e] = 1'($urandom);
                for (int b = 0; b < MB; b++) elemData[e][b] = 8'($urandom);
            end
            m = step(m);
            cyc();
            chk("rnd_valid", 64'(mIf.msgValid), 64'(m.valid));
            chk("rnd_len", 64'(mIf.msgLen), 64'(m.len));
            chk("rnd_last", 64'(mIf.msgLast), 64'(m.last));
            chkData("rnd_data", mIf.msgData, m.data);
            chk("rnd_taken", 64'(elemTaken), 64'(m.taken));
            chk("rnd_head", 64'(head), 64'(m.head));
            chk("rnd_cnt", 64'(msgCount), 64'(m.cnt));
            chk("rnd_bytes", 64'(byteCount), 64'(m.bytes));
            chk("rnd_lenErr", 64'(lenError), 64'(m.lenErr));
            chk("rnd_fd", 64'(frameDone), 64'(m.fd));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/use_drain_scheduler.md
USE_DRAIN_SCHEDULER -- requirements
Module: use_drain_scheduler

Interface
REQ-001 SHALL have parameter NUM_ELEMENTS, default 4: number of stream elements drained; legal range 2..16.
REQ-002 SHALL have parameter MAX_UNCOMPRESSED_BYTES, default 34: bytes per element message slot.
REQ-003 SHALL have parameter LEN_W, default $clog2(MAX_UNCOMPRESSED_BYTES): width of all length fields.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  when low, no new capture starts; the message in flight still completes.
REQ-007 elemData  input  [NUM_ELEMENTS][MAX_UNCOMPRESSED_BYTES][8]  per-element message bytes, byte 0 first.
REQ-008 elemLen  input  [NUM_ELEMENTS][LEN_W]  per-element byte length; nonzero means a message is ready.
REQ-009 elemLast  input  [NUM_ELEMENTS]  per-element tlast-seen flag.
REQ-010 elemTaken  output  [NUM_ELEMENTS]  one-cycle, one-hot pulse releasing the captured element.
REQ-011 msgData  output  [MAX_UNCOMPRESSED_BYTES][8]  registered message bytes.
REQ-012 msgLen  output  LEN_W  registered message length.
REQ-013 msgLast  output  1  registered last flag.
REQ-014 msgValid  output  1  message valid; follows AXI-Stream valid/ready rules.
REQ-015 msgReady  input  1  downstream accept.
REQ-016 head  output  $clog2(NUM_ELEMENTS)  index of the next element to be drained.
REQ-017 msgCount  output  16  accepted-message counter; wraps at 2^16.
REQ-018 byteCount  output  32  sum of accepted msgLen; wraps at 2^32.
REQ-019 lenError  output  1  sticky; set when a captured elemLen exceeds MAX_UNCOMPRESSED_BYTES.
REQ-020 frameDone  output  1  one-cycle pulse on acceptance of a message with msgLast=1.

Function
REQ-021 SHALL drain elements strictly in ring order (head, head+1, ... wrapping NUM_ELEMENTS-1 to 0), matching the token order; a ready non-head element SHALL be ignored until head reaches it.
REQ-022 SHALL implement states S_WAIT (msgValid=0) and S_HOLD (msgValid=1).
REQ-023 capture condition = enable && elemLen[head]!=0 && (S_WAIT || (S_HOLD && msgReady)).
REQ-024 on the capture edge SHALL register elemData/elemLen/elemLast[head] into msg*, set elemTaken[head] for exactly the next cycle, advance head modulo NUM_ELEMENTS, and enter or stay in S_HOLD.
REQ-025 latency: elemLen[head] nonzero in cycle t (S_WAIT) -> msgValid and elemTaken high in cycle t+1.
REQ-026 in S_HOLD with msgReady=1 and no capture SHALL go to S_WAIT; with msgReady=0, msgData/msgLen/msgLast SHALL hold stable.
REQ-027 back-to-back capture per REQ-023 SHALL sustain one message per cycle.
REQ-028 on acceptance (msgValid && msgReady): msgCount += 1, byteCount += msgLen, frameDone pulses if msgLast=1.
REQ-029 elemLen > MAX_UNCOMPRESSED_BYTES: msgLen SHALL be clamped to MAX_UNCOMPRESSED_BYTES and lenError set until reset.
REQ-030 enable deasserted in S_HOLD: current message SHALL still be presented until accepted, then go to S_WAIT with no new capture.
REQ-031 elemTaken SHALL never be asserted for more than one element or for more than one cycle per capture.

Reset
REQ-032 reset SHALL force S_WAIT, head=0, msgValid=0, msgData=0, msgLen=0, msgLast=0, elemTaken=0, msgCount=0, byteCount=0, lenError=0, frameDone=0.
REQ-033 reset mid-message SHALL drop the in-flight message with no elemTaken or frameDone pulse issued.

Structure
REQ-034 package use_sched_pkg SHALL hold the state enum and the LEN_W and NUM_ELEMENTS-derived index width constants.
REQ-035 statistics (msgCount, byteCount, lenError) SHALL be one sub-module, use_sched_stats; everything else stays inline.

Verification
REQ-036 N=4; elem0 len=27 in cycle 5, msgReady=1 -> cycle 6: msgValid=1, msgLen=27, elemTaken=4'b0001; cycle 7: head=1, msgCount=1.
REQ-037 elem2 ready, elem1 not, head=1 -> no capture until elem1 ready; elem1 then elem2 drained on consecutive cycles.
REQ-038 all 4 elements ready, msgReady=1 -> four messages on 4 consecutive cycles; head wraps to 0; byteCount = sum of lengths.
REQ-039 msgReady=0 for 5 cycles -> msgData/msgLen stable, no further elemTaken; release -> accepted in 1 cycle.
REQ-040 elemLen=40 -> msgLen=34, lenError=1 until reset; elemLast=1 message accepted -> frameDone one cycle.
REQ-041 reset asserted during S_HOLD -> next cycle msgValid=0, head=0, counters=0, no elemTaken pulse.
